// File: rtl/layer_pipe_sched.sv
// Image-level scheduler for the three-layer streaming datapath: layer start pulses, ping-pong buffer
// occupancy/bank tracking and result handshake. Define SCHED_STALL_CNT_EN to build the stall counters.
module layer_pipe_sched #(
    parameter int NUM_IMG = 10000,
    parameter int CNT_W   = 14
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic             img_valid_i,
    output logic             img_ready_o,
    output logic             l1_start_o,
    output logic             l2_start_o,
    output logic             l3_start_o,
    input  logic             l1_done_i,
    input  logic             l2_done_i,
    input  logic             l3_done_i,
    output logic             b1_wbank_o,
    output logic             b1_rbank_o,
    output logic             b2_wbank_o,
    output logic             b2_rbank_o,
    output logic             b3_wbank_o,
    output logic             b3_rbank_o,
    output logic             result_valid_o,
    input  logic             result_ready_i,
    output logic [CNT_W-1:0] img_cnt_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [31:0]      stall1_o,
    output logic [31:0]      stall2_o,
    output logic [31:0]      stall3_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] NUM_IMG_C  = CNT_W'(NUM_IMG);
    localparam logic [CNT_W-1:0] LAST_IMG_C = CNT_W'(NUM_IMG - 1);

    state_e           state_q, state_d;
    logic [2:0][1:0]  occ_q, occ_d;
    logic [2:0]       wptr_q, wptr_d;
    logic [2:0]       rptr_q, rptr_d;
    logic [2:0]       busy_q, busy_d;
    logic [2:0]       start_q, start_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] img_cnt_q, img_cnt_d;
    logic             err_q, err_d;

    logic       run;
    logic       run_start;
    logic       issue_left;
    logic       l1_ready;
    logic       pop;
    logic [2:0] done_in;
    logic [2:0] done_ok;
    logic [2:0] done_bad;
    logic [2:0] start_go;
    logic [2:0] produce;
    logic [2:0] consume;

    assign run        = (state_q == ST_RUN);
    assign run_start  = (state_q != ST_RUN) & start_i;
    assign issue_left = (issued_q < NUM_IMG_C);
    assign done_in    = {l3_done_i, l2_done_i, l1_done_i};
    assign done_ok    = {3{run}} & done_in & busy_q;
    assign done_bad   = {3{run}} & done_in & ~busy_q;
    assign pop        = run & (occ_q[2] != 2'd0) & result_ready_i;

    assign l1_ready    = run & ~busy_q[0] & issue_left & (occ_q[0] < 2'd2);
    assign start_go[0] = l1_ready & img_valid_i;
    assign start_go[1] = run & ~busy_q[1] & (occ_q[0] != 2'd0) & (occ_q[1] < 2'd2);
    assign start_go[2] = run & ~busy_q[2] & (occ_q[1] != 2'd0) & (occ_q[2] < 2'd2);

    // Layer k fills Bk; the next layer (or the result handshake for B3) drains it on completion,
    // so a slot stays counted for as long as its consumer is still reading it.
    assign produce = done_ok;
    assign consume = {pop, done_ok[2], done_ok[1]};

    // NOTE: every next-state variable gets its default first so no path leaves one unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        occ_d     = occ_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        busy_d    = busy_q;
        start_d   = '0;
        issued_d  = issued_q;
        img_cnt_d = img_cnt_q;
        err_d     = err_q;
        unique case (state_q)
            ST_RUN: begin
                for (int k = 0; k < 3; k++) begin
                    occ_d[k] = occ_q[k] + 2'(produce[k]) - 2'(consume[k]);
                end
                wptr_d    = wptr_q ^ produce;
                rptr_d    = rptr_q ^ consume;
                busy_d    = start_go | (busy_q & ~done_ok);
                start_d   = start_go;
                issued_d  = issued_q + CNT_W'(start_go[0]);
                img_cnt_d = img_cnt_q + CNT_W'(pop);
                err_d     = err_q | (|done_bad);
                if (pop && (img_cnt_q == LAST_IMG_C)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                if (start_i) begin
                    state_d   = ST_RUN;
                    occ_d     = '0;
                    wptr_d    = '0;
                    rptr_d    = '0;
                    busy_d    = '0;
                    issued_d  = '0;
                    img_cnt_d = '0;
                    err_d     = 1'b0;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_IDLE;
            occ_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            busy_q    <= '0;
            start_q   <= '0;
            issued_q  <= '0;
            img_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            occ_q     <= occ_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
            issued_q  <= issued_d;
            img_cnt_q <= img_cnt_d;
            err_q     <= err_d;
        end
    end

`ifdef SCHED_STALL_CNT_EN
    logic [2:0]       stall_cond;
    logic [2:0][31:0] stall_q, stall_d;

    // A stage stalls when it could run but its output buffer has no free bank.
    assign stall_cond[0] = run & ~busy_q[0] & img_valid_i & issue_left & (occ_q[0] == 2'd2);
    assign stall_cond[1] = run & ~busy_q[1] & (occ_q[0] != 2'd0) & (occ_q[1] == 2'd2);
    assign stall_cond[2] = run & ~busy_q[2] & (occ_q[1] != 2'd0) & (occ_q[2] == 2'd2);

    always_comb begin
        stall_d = stall_q;
        if (run_start) begin
            stall_d = '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (stall_cond[k] && (stall_q[k] != 32'hFFFF_FFFF)) begin
                    stall_d[k] = stall_q[k] + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall1_o = stall_q[0];
    assign stall2_o = stall_q[1];
    assign stall3_o = stall_q[2];
`else
    assign stall1_o = 32'd0;
    assign stall2_o = 32'd0;
    assign stall3_o = 32'd0;
`endif

    assign img_ready_o    = l1_ready;
    assign l1_start_o     = start_q[0];
    assign l2_start_o     = start_q[1];
    assign l3_start_o     = start_q[2];
    assign b1_wbank_o     = wptr_q[0];
    assign b1_rbank_o     = rptr_q[0];
    assign b2_wbank_o     = wptr_q[1];
    assign b2_rbank_o     = rptr_q[1];
    assign b3_wbank_o     = wptr_q[2];
    assign b3_rbank_o     = rptr_q[2];
    assign result_valid_o = (occ_q[2] != 2'd0);
    assign img_cnt_o      = img_cnt_q;
    assign busy_o         = run;
    assign done_o         = (state_q == ST_DONE);
    assign err_o          = err_q;

endmodule

// File: tb/tb_layer_pipe_sched.sv
// Bench for layer_pipe_sched: queue-based image-flow model checked every cycle, plus directed
// scenarios (full run, back-pressure, simultaneous done, spurious done, mid-run reset) and random runs.
module tb_layer_pipe_sched;

    localparam int N      = 8;
    localparam int CW     = 4;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    logic          clk = 1'b0;
    logic          rstn_i;
    logic          start_i;
    logic          img_valid_i;
    logic          result_ready_i;
    logic [2:0]    done_v;
    logic          l1_done_i, l2_done_i, l3_done_i;
    logic          img_ready_o;
    logic          l1_start_o, l2_start_o, l3_start_o;
    logic          b1_wbank_o, b1_rbank_o, b2_wbank_o, b2_rbank_o, b3_wbank_o, b3_rbank_o;
    logic          result_valid_o;
    logic [CW-1:0] img_cnt_o;
    logic          busy_o, done_o, err_o;
    logic [31:0]   stall1_o, stall2_o, stall3_o;

    assign l1_done_i = done_v[0];
    assign l2_done_i = done_v[1];
    assign l3_done_i = done_v[2];

    always #5 clk = ~clk;

    layer_pipe_sched #(.NUM_IMG(N), .CNT_W(CW)) dut (
        .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i),
        .img_valid_i(img_valid_i), .img_ready_o(img_ready_o),
        .l1_start_o(l1_start_o), .l2_start_o(l2_start_o), .l3_start_o(l3_start_o),
        .l1_done_i(l1_done_i), .l2_done_i(l2_done_i), .l3_done_i(l3_done_i),
        .b1_wbank_o(b1_wbank_o), .b1_rbank_o(b1_rbank_o),
        .b2_wbank_o(b2_wbank_o), .b2_rbank_o(b2_rbank_o),
        .b3_wbank_o(b3_wbank_o), .b3_rbank_o(b3_rbank_o),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .img_cnt_o(img_cnt_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .stall1_o(stall1_o), .stall2_o(stall2_o), .stall3_o(stall3_o)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: buffers hold image ids; banks follow produced/consumed counts modulo 2.
    int m_state;
    int q1[$], q2[$], q3[$];
    int prod[3], cons[3], m_stall[3];
    bit m_busy[3], m_pulse[3];
    int m_issued, m_retired, l1_id;
    bit m_err;

    // Layer-controller emulation and observation.
    bit auto_mode, rand_lat;
    int lat_cnt[3];
    int n_st[3];
    int wb1_seq[$], rb1_seq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input int st);
        q1.delete(); q2.delete(); q3.delete();
        for (int k = 0; k < 3; k++) begin
            prod[k] = 0; cons[k] = 0; m_stall[k] = 0; m_busy[k] = 0; m_pulse[k] = 0;
        end
        m_issued = 0; m_retired = 0; l1_id = 0; m_err = 0;
        m_state = st;
    endtask

    task automatic check_outputs();
        bit run;
        run = (m_state == S_RUN);
        check("img_ready", img_ready_o, run && !m_busy[0] && m_issued < N && q1.size() < 2);
        check("l1_start", l1_start_o, m_pulse[0]);
        check("l2_start", l2_start_o, m_pulse[1]);
        check("l3_start", l3_start_o, m_pulse[2]);
        check("b1_wbank", b1_wbank_o, prod[0] % 2);
        check("b1_rbank", b1_rbank_o, cons[0] % 2);
        check("b2_wbank", b2_wbank_o, prod[1] % 2);
        check("b2_rbank", b2_rbank_o, cons[1] % 2);
        check("b3_wbank", b3_wbank_o, prod[2] % 2);
        check("b3_rbank", b3_rbank_o, cons[2] % 2);
        check("result_valid", result_valid_o, q3.size() > 0);
        check("img_cnt", img_cnt_o, m_retired);
        check("busy", busy_o, run);
        check("done", done_o, m_state == S_DONE);
        check("err", err_o, m_err);
`ifdef SCHED_STALL_CNT_EN
        check("stall1", stall1_o, m_stall[0]);
        check("stall2", stall2_o, m_stall[1]);
        check("stall3", stall3_o, m_stall[2]);
`else
        check("stall1", stall1_o, 0);
        check("stall2", stall2_o, 0);
        check("stall3", stall3_o, 0);
`endif
    endtask

    task automatic model_update();
        bit go[3], dv[3], dn[3];
        bit pop;
        dn[0] = l1_done_i; dn[1] = l2_done_i; dn[2] = l3_done_i;
        if (m_state != S_RUN) begin
            for (int k = 0; k < 3; k++) m_pulse[k] = 0;
            if (start_i) model_clear(S_RUN);
        end else begin
            go[0] = !m_busy[0] && m_issued < N && q1.size() < 2 && img_valid_i;
            go[1] = !m_busy[1] && q1.size() > 0 && q2.size() < 2;
            go[2] = !m_busy[2] && q2.size() > 0 && q3.size() < 2;
            if (!m_busy[0] && img_valid_i && m_issued < N && q1.size() == 2) m_stall[0]++;
            if (!m_busy[1] && q1.size() > 0 && q2.size() == 2) m_stall[1]++;
            if (!m_busy[2] && q2.size() > 0 && q3.size() == 2) m_stall[2]++;
            pop = q3.size() > 0 && result_ready_i;
            for (int k = 0; k < 3; k++) begin
                dv[k] = dn[k] && m_busy[k];
                if (dn[k] && !m_busy[k]) m_err = 1;
            end
            if (pop)   begin void'(q3.pop_front()); cons[2]++; m_retired++; end
            if (dv[2]) begin q3.push_back(q2.pop_front()); cons[1]++; prod[2]++; end
            if (dv[1]) begin q2.push_back(q1.pop_front()); cons[0]++; prod[1]++; end
            if (dv[0]) begin q1.push_back(l1_id); prod[0]++; end
            if (go[0]) begin l1_id = m_issued; m_issued++; end
            for (int k = 0; k < 3; k++) begin
                if (go[k]) m_busy[k] = 1;
                else if (dv[k]) m_busy[k] = 0;
                m_pulse[k] = go[k];
            end
            if (m_retired == N) m_state = S_DONE;
        end
    endtask

    // One clock: check outputs for the current inputs, advance the model, then emulate the layers.
    task automatic tick();
        logic [2:0] st;
        #1;
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
        st = {l3_start_o, l2_start_o, l1_start_o};
        if (l1_start_o === 1'b1) wb1_seq.push_back(int'(b1_wbank_o));
        if (l2_start_o === 1'b1) rb1_seq.push_back(int'(b1_rbank_o));
        for (int k = 0; k < 3; k++) begin
            if (st[k] === 1'b1) n_st[k]++;
            done_v[k] = 1'b0;
            if (auto_mode) begin
                if (lat_cnt[k] > 0) begin
                    lat_cnt[k]--;
                    done_v[k] = (lat_cnt[k] == 0);
                end
                if (st[k] === 1'b1) lat_cnt[k] = rand_lat ? int'($urandom_range(1, 6)) : 5;
            end
        end
    endtask

    task automatic pulse_done(input logic [2:0] mask);
        done_v = mask;
        tick();
        done_v = 3'b000;
    endtask

    task automatic start_run();
        for (int k = 0; k < 3; k++) n_st[k] = 0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        for (int c = 0; c < budget && m_state != S_DONE; c++) tick();
    endtask

    initial begin
        rstn_i = 1'b0; start_i = 1'b0; img_valid_i = 1'b0; result_ready_i = 1'b0;
        done_v = 3'b000; auto_mode = 1'b1; rand_lat = 1'b0;
        for (int k = 0; k < 3; k++) begin lat_cnt[k] = 0; n_st[k] = 0; end
        model_clear(S_IDLE);

        // Reset state.
        #3;
        check_outputs();
        @(posedge clk); #1;
        rstn_i = 1'b1;
        tick(); tick();

        // Full run, all layers respond after 5 cycles, consumer always ready.
        img_valid_i = 1'b1; result_ready_i = 1'b1;
        wb1_seq.delete(); rb1_seq.delete();
        start_run();
        run_to_done(600);
        check("A_l1_pulses", n_st[0], N);
        check("A_l2_pulses", n_st[1], N);
        check("A_l3_pulses", n_st[2], N);
        check("A_img_cnt", img_cnt_o, N);
        check("A_done", done_o, 1);
        check("A_busy", busy_o, 0);
        check("A_err", err_o, 0);
        for (int i = 0; i < 4; i++) begin
            check("A_b1_wbank_seq", (i < wb1_seq.size()) ? wb1_seq[i] : 32'hDEAD, i % 2);
            check("A_b1_rbank_seq", (i < rb1_seq.size()) ? rb1_seq[i] : 32'hDEAD, i % 2);
        end

        // Back-pressure: consumer never ready, pipeline fills and freezes.
        result_ready_i = 1'b0;
        start_run();
        for (int c = 0; c < 200; c++) tick();
        check("B_l1_pulses", n_st[0], 6);
        check("B_l2_pulses", n_st[1], 4);
        check("B_l3_pulses", n_st[2], 2);
        check("B_img_ready", img_ready_o, 0);
        check("B_result_valid", result_valid_o, 1);
        result_ready_i = 1'b1;
        run_to_done(600);
        check("B_img_cnt", img_cnt_o, N);
        check("B_done", done_o, 1);

        // Directed: L2 and L3 finish together with one image in B2, then a spurious L1 done.
        auto_mode = 1'b0; img_valid_i = 1'b0; result_ready_i = 1'b0;
        start_run();
        img_valid_i = 1'b1; tick(); img_valid_i = 1'b0;
        pulse_done(3'b001);
        tick();
        pulse_done(3'b010);
        img_valid_i = 1'b1; tick(); img_valid_i = 1'b0;
        pulse_done(3'b001);
        tick();
        check("C_b2_wbank_before", b2_wbank_o, 1);
        check("C_b2_rbank_before", b2_rbank_o, 0);
        pulse_done(3'b110);
        check("C_b2_wbank_after", b2_wbank_o, 0);
        check("C_b2_rbank_after", b2_rbank_o, 1);
        check("C_err_clean", err_o, 0);
        pulse_done(3'b001);
        check("D_err_set", err_o, 1);
        check("D_b1_wbank_kept", b1_wbank_o, 0);
        pulse_done(3'b100);
        tick(); tick();
        check("D_err_sticky", err_o, 1);

        // Finish that run in auto mode; err survives into DONE and clears on the next start.
        auto_mode = 1'b1; img_valid_i = 1'b1; result_ready_i = 1'b1;
        run_to_done(600);
        check("D_done", done_o, 1);
        check("D_err_in_done", err_o, 1);
        start_run();
        check("D_err_cleared", err_o, 0);

        // Reset while L2 is busy, then a stale L2 done after release.
        for (int c = 0; c < 100 && !m_busy[1]; c++) tick();
        check("E_l2_busy_reached", m_busy[1], 1);
        #2 rstn_i = 1'b0;
        #1;
        model_clear(S_IDLE);
        auto_mode = 1'b0; done_v = 3'b000;
        for (int k = 0; k < 3; k++) lat_cnt[k] = 0;
        check_outputs();
        @(posedge clk); #1;
        rstn_i = 1'b1;
        pulse_done(3'b010);
        tick(); tick();
        check("E_err_after_stale", err_o, 0);
        check("E_idle_busy", busy_o, 0);
        check("E_idle_done", done_o, 0);
        auto_mode = 1'b1;
        start_run();
        run_to_done(600);
        check("E_clean_cnt", img_cnt_o, N);
        check("E_clean_err", err_o, 0);

        // Randomized runs: random latencies, valid/ready patterns and ignored starts during RUN.
        rand_lat = 1'b1;
        for (int r = 0; r < 3; r++) begin
            start_run();
            for (int c = 0; c < 3000 && m_state != S_DONE; c++) begin
                img_valid_i    = 1'($urandom_range(0, 1));
                result_ready_i = ($urandom_range(0, 3) != 0);
                start_i        = ($urandom_range(0, 15) == 0);
                tick();
            end
            start_i = 1'b0;
            check("R_done", done_o, 1);
            check("R_img_cnt", img_cnt_o, N);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/layer_pipe_sched.md
Name: layer_pipe_sched

Overview:
- Image-level scheduler for the three-layer MNIST streaming datapath. It issues start pulses to the per-layer local controllers (layer1/2/3) so that up to three images are in flight at once.
- Tracks occupancy of the ping-pong activation buffers between layers and drives their bank selects.
- Accepts images via a valid/ready handshake and retires results via a valid/ready handshake to the classifier/argmax stage.

Parameters:
- NUM_IMG, 10000, images processed per run.
- CNT_W, 14, width of image counters; must satisfy 2^CNT_W > NUM_IMG.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  pulse; begins a run from IDLE or DONE.
- img_valid_i  in  1  input image available in input memory.
- img_ready_o  out  1  scheduler accepts image this cycle.
- l1_start_o, l2_start_o, l3_start_o  out  1 each  one-cycle start pulse to the layer controller.
- l1_done_i, l2_done_i, l3_done_i  in  1 each  one-cycle done pulse from the layer controller.
- b1_wbank_o, b1_rbank_o  out  1 each  B1 (L1->L2) write/read bank.
- b2_wbank_o, b2_rbank_o  out  1 each  B2 (L2->L3) write/read bank.
- b3_wbank_o, b3_rbank_o  out  1 each  B3 (L3->result) write/read bank.
- result_valid_o  out  1  B3 holds a finished result.
- result_ready_i  in  1  consumer takes result.
- img_cnt_o  out  CNT_W  images retired this run.
- busy_o  out  1  FSM in RUN.
- done_o  out  1  FSM in DONE.
- err_o  out  1  sticky protocol error.
- stall1_o, stall2_o, stall3_o  out  32 each  back-pressure stall counters (see Optional Feature).

Behaviour:
- Reset: async. FSM=IDLE; all outputs, pointers, occupancies, busy flags and counters = 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE->RUN on start_i.
  - RUN->DONE on the edge where the retire count reaches NUM_IMG.
  - DONE->RUN on start_i. Entering RUN from IDLE or DONE clears counters, pointers, occupancies and err_o.
  - start_i during RUN is ignored.
- Per buffer Bk:
  - occ_k is 0..2.
  - wptr_k toggles on producer done; rptr_k toggles on consumer done (B3: on result handshake).
  - occ_k increments on producer done and decrements on consumer done/pop.
  - Simultaneous increment and decrement: occ unchanged, both pointers toggle.
  - A slot stays counted until its consumer finishes.
- Stage-start conditions (stage k idle, i.e. busy_k=0):
  - L1: RUN, issued<NUM_IMG, occ1<2. img_ready_o is driven combinationally from this. A transfer is img_valid_i & img_ready_o.
  - L2: RUN, occ1>0, occ2<2.
  - L3: RUN, occ2>0, occ3<2.
- Start timing: on the start edge, busy_k<=1 and lk_start_o<=1 for exactly one cycle, so the pulse is visible the following cycle. busy_k clears on lk_done_i.
- Start-to-start latency: minimum 1 cycle after done.
- Bank selects: bk_wbank_o=wptr_k; bk_rbank_o=rptr_k. Both are stable while the corresponding stage is busy.
- Result output: result_valid_o=occ3>0. A handshake pops B3 and increments img_cnt_o.
- issued counter: increments per L1 transfer and saturates at NUM_IMG. After NUM_IMG transfers, img_ready_o stays low.
- Protocol errors: lk_done_i while busy_k=0 in RUN sets err_o; occ and pointers are unchanged. Done pulses in IDLE/DONE are ignored silently.
- Reset mid-run: everything returns to 0 immediately. Stale done pulses after release are ignored (FSM is in IDLE).

Optional Feature:
- Macro: SCHED_STALL_CNT_EN.
- Defined:
  - stallk_o counts RUN cycles in which stage k is idle, its input is available (L1: img_valid_i & issued<NUM_IMG; L2: occ1>0; L3: occ2>0) and its output buffer is full (occ=2).
  - Counters are 32-bit saturating, cleared on reset and on run start.
- Undefined: stall1_o, stall2_o and stall3_o are tied to 0 and no counter logic is generated.

Test Plan:
- NUM_IMG=4, img_valid_i=1, every layer returns done 5 cycles after start, result_ready_i=1 -> exactly 4 pulses each of l1/l2/l3_start_o; img_cnt_o=4; done_o=1, busy_o=0; err_o=0.
- NUM_IMG=8, result_ready_i=0 -> exactly 6 l1_start_o, 4 l2_start_o, 2 l3_start_o; then img_ready_o=0 and result_valid_o=1. Releasing result_ready_i -> all 8 retire, done_o=1.
- Bank sequencing over 4 images -> b1_wbank_o at successive l1_start_o = 0,1,0,1; b1_rbank_o at successive l2_start_o = 0,1,0,1; b3_rbank_o toggles per handshake.
- occ2=1 with l2_done_i and l3_done_i in the same cycle -> occ2 stays 1; b2_wbank_o and b2_rbank_o both toggle.
- rstn_i low while busy2=1, then released and l2_done_i pulsed -> all outputs 0 immediately; FSM stays IDLE; err_o=0. start_i then runs cleanly.
- Spurious l1_done_i in RUN with busy1=0 -> err_o=1 (sticky); occ1 unchanged. err_o is cleared by next start_i from DONE.
